// File: rtl/seq_divider_if.sv
// Division handshake bundle between the EX stage (master) and the
// sequential divider (slave). EX drives operands/start/annul; the divider
// answers with ready and {remainder, quotient}.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: one-bit-per-cycle restoring divider for DIV / DIVU.
// Result is {remainder, quotient}; ready_o is held while start_i stays high.
// Optional build macro: DIV_EARLY_OUT_EN -- skips the iterations when
// |dividend| < |divisor|, answering through the one-cycle short path.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start_i; operands latched on acceptance
// ON      | one restoring step per cycle, WIDTH steps total
// DIVZERO | one-cycle short path (zero divisor, or early-out)
// END     | ready_o high, result_o valid; leave when start_i drops
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  dif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ON      = 2'd1,
        S_DIVZERO = 2'd2,
        S_END     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    divisor_q, divisor_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                early_q, early_d;
    logic [2*WIDTH-1:0]  result_q, result_d;

    logic                sign1, sign2;
    logic [WIDTH-1:0]    abs1, abs2;
    logic                early_hit;
    logic [WIDTH:0]      trial;
    logic [WIDTH-1:0]    step_rem, step_quo;

    // Signed fix-up: quotient negated on sign mismatch, remainder follows the dividend.
    function automatic logic [2*WIDTH-1:0] fix_sign(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic             neg_quo,
        input logic             neg_rem
    );
        logic [WIDTH-1:0] r, q;
        r = neg_rem ? (~rem + 1'b1) : rem;
        q = neg_quo ? (~quo + 1'b1) : quo;
        return {r, q};
    endfunction

    // Magnitudes of the incoming operands; unsigned operands pass unchanged.
    always_comb begin
        sign1 = dif.signed_div_i & dif.opdata1_i[WIDTH-1];
        sign2 = dif.signed_div_i & dif.opdata2_i[WIDTH-1];
        abs1  = sign1 ? (~dif.opdata1_i + 1'b1) : dif.opdata1_i;
        abs2  = sign2 ? (~dif.opdata2_i + 1'b1) : dif.opdata2_i;
`ifdef DIV_EARLY_OUT_EN
        early_hit = (abs1 < abs2);
`else
        early_hit = 1'b0;
`endif
    end

    // One restoring step: the next dividend bit enters the partial remainder
    // from the top of the quotient register, which doubles as the dividend shifter.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, divisor_q};
        step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        early_d   = early_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                result_d = '0;
                if (dif.start_i && !dif.annul_i) begin
                    cnt_d     = '0;
                    rem_d     = '0;
                    quo_d     = abs1;
                    divisor_d = abs2;
                    neg_quo_d = sign1 ^ sign2;
                    neg_rem_d = sign1;
                    if (dif.opdata2_i == '0) begin
                        early_d = 1'b0;
                        state_d = S_DIVZERO;
                    end else if (early_hit) begin
                        early_d = 1'b1;
                        state_d = S_DIVZERO;
                    end else begin
                        early_d = 1'b0;
                        state_d = S_ON;
                    end
                end
            end
            S_ON: begin
                if (dif.annul_i) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    result_d = '0;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) begin
                        cnt_d    = '0;
                        state_d  = S_END;
                        result_d = fix_sign(step_rem, step_quo, neg_quo_q, neg_rem_q);
                    end
                end
            end
            S_DIVZERO: begin
                if (dif.annul_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                end else begin
                    state_d  = S_END;
                    // Early-out: quotient 0, remainder is the dividend with its sign restored.
                    result_d = early_q ? fix_sign(quo_q, '0, 1'b0, neg_rem_q) : '0;
                end
            end
            S_END: begin
                if (dif.annul_i || !dif.start_i) begin
                    state_d  = S_IDLE;
                    result_d = '0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                result_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            early_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            early_q   <= early_d;
            result_q  <= result_d;
        end
    end

    // Result is only visible while in END; zero otherwise.
    always_comb begin
        dif.ready_o  = (state_q == S_END);
        dif.result_o = (state_q == S_END) ? result_q : '0;
    end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a driver issues divisions and pushes the expected
// {remainder, quotient} and arrival cycle; a monitor pops on each ready pulse.
module tb_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(W)) dif ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .dif(dif));

    typedef struct {
        logic [2*W-1:0] res;
        int             cyc;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc++;

    function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 0) return '0;
        if (!s) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[W-1:0], qv[W-1:0]};
    endfunction

    function automatic int latency(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        if (b == 0) return 2;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        if (sa < 0) sa = -sa;
        if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_OUT_EN
        if (sa < sb) return 2;
`endif
        return W + 1;
    endfunction

    // Monitor: scoreboard pop on ready rise, hold stability, zero when not ready.
    logic           rdy_prev = 1'b0;
    logic [2*W-1:0] res_prev = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rdy_prev = 1'b0;
        end else begin
            vectors++;
            if (dif.ready_o && !rdy_prev) begin
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready at cycle %0d result=%h", cyc, dif.result_o);
                end else begin
                    e = sbq.pop_front();
                    if (dif.result_o !== e.res || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result got=%h exp=%h cycle got=%0d exp=%0d",
                                 dif.result_o, e.res, cyc, e.cyc);
                    end
                end
            end else if (dif.ready_o && rdy_prev) begin
                if (dif.result_o !== res_prev) begin
                    errors++;
                    $display("FAIL hold_stable got=%h exp=%h", dif.result_o, res_prev);
                end
            end else if (dif.result_o !== '0) begin
                errors++;
                $display("FAIL idle_zero got=%h exp=0", dif.result_o);
            end
            rdy_prev = dif.ready_o;
            res_prev = dif.result_o;
        end
    end

    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        dif.signed_div_i = s;
        dif.opdata1_i    = a;
        dif.opdata2_i    = b;
        dif.start_i      = 1'b1;
        e.res = model(s, a, b);
        e.cyc = cyc + latency(s, a, b);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        dif.opdata1_i    = $urandom;
        dif.opdata2_i    = $urandom;
        dif.signed_div_i = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dif.ready_o && n < 100);
        if (!dif.ready_o) begin
            vectors++;
            errors++;
            $display("FAIL timeout waiting ready a=%h b=%h got=0 exp=1", a, b);
            sbq.delete();
        end
        repeat (hold) @(negedge clk);
        dif.start_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (dif.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_drop got=%b exp=0", dif.ready_o);
        end
    endtask

    task automatic watch_no_ready(input string name);
        int seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (dif.ready_o) seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s ready cycles got=%0d exp=0", name, seen);
        end
    endtask

    task automatic annul_op();
        @(posedge clk);
        #1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        dif.annul_i = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        dif.annul_i = 1'b0;
        watch_no_ready("annul");
    endtask

    task automatic reset_mid_op();
        @(posedge clk);
        #1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = 32'd100;
        dif.opdata2_i    = 32'd3;
        dif.start_i      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst         = 1'b1;
        dif.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (dif.ready_o !== 1'b0 || dif.result_o !== '0) begin
            errors++;
            $display("FAIL reset_mid_op ready=%b result=%h exp 0/0", dif.ready_o, dif.result_o);
        end
        watch_no_ready("reset_mid_op");
    endtask

    initial begin
        logic [W-1:0] a, b;
        rst              = 1'b1;
        dif.signed_div_i = 1'b0;
        dif.opdata1_i    = '0;
        dif.opdata2_i    = '0;
        dif.start_i      = 1'b0;
        dif.annul_i      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (dif.ready_o !== 1'b0 || dif.result_o !== '0) begin
            errors++;
            $display("FAIL reset_state ready=%b result=%h exp 0/0", dif.ready_o, dif.result_o);
        end

        run_op(1'b0, 32'd7, 32'd2, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'h1234_5678, 32'd0, 0);
        run_op(1'b1, 32'h1234_5678, 32'd0, 2);
        annul_op();
        run_op(1'b0, 32'd100, 32'd3, 0);
        run_op(1'b0, 32'd5, 32'd9, 3);
        reset_mid_op();
        run_op(1'b0, 32'd100, 32'd3, 0);
        run_op(1'b1, 32'hFFFF_FFFB, 32'd9, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1);
        run_op(1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 0);

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 20);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = $urandom_range(1, 15);
                2:       b = ~($urandom_range(0, 15));
                default: b = $urandom;
            endcase
            run_op(1'($urandom), a, b, $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        if (sbq.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL pending_expected got=%0d exp=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
